// File: rtl/object_updater_pkg.sv
// Shared constants for the object updater: storage mode codes, direction
// encodings, grid limits and the controller state encoding.
package object_updater_pkg;

  // Storage object select codes, one per slot
  localparam logic [3:0] MODE_NONE  = 4'b0000;
  localparam logic [3:0] MODE_TANK1 = 4'b0001;
  localparam logic [3:0] MODE_TANK2 = 4'b0011;
  localparam logic [3:0] MODE_PROJ1 = 4'b0101;
  localparam logic [3:0] MODE_PROJ2 = 4'b0111;

  // Direction byte layout: bit 7 marks the object active, bits [1:0] heading
  localparam int         ACTIVE_BIT = 7;
  localparam logic [1:0] DIR_UP     = 2'b00;
  localparam logic [1:0] DIR_RIGHT  = 2'b01;
  localparam logic [1:0] DIR_DOWN   = 2'b10;
  localparam logic [1:0] DIR_LEFT   = 2'b11;

  // Grid coordinate limits (4-bit x and y)
  localparam logic [3:0] GRID_MIN = 4'h0;
  localparam logic [3:0] GRID_MAX = 4'hF;

  // Slots 0,1 are tanks, slots 2,3 are projectiles
  localparam logic [1:0] LAST_SLOT = 2'd3;

  // Controller state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CALC  = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Map a slot index onto its storage mode code
  function automatic logic [3:0] slot_mode(input logic [1:0] slot);
    logic [3:0] code;
    case (slot)
      2'd0:    code = MODE_TANK1;
      2'd1:    code = MODE_TANK2;
      2'd2:    code = MODE_PROJ1;
      default: code = MODE_PROJ2;
    endcase
    return code;
  endfunction

  // Projectiles occupy the upper two slots
  function automatic logic slot_is_proj(input logic [1:0] slot);
    return slot[1];
  endfunction

endpackage

// File: rtl/object_updater_pos_step.sv
// One-step movement of an object on the 16x16 grid. Moving off the grid is
// blocked: the position holds, and a projectile is deactivated instead.
module pos_step
  import object_updater_pkg::*;
(
  input  logic [7:0] pos,
  input  logic [7:0] dir,
  input  logic       is_proj,
  output logic [7:0] new_pos,
  output logic [7:0] new_dir
);

  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] nx;
  logic [3:0] ny;
  logic       at_edge;

  // Step one coordinate by one in the heading, or flag an outward edge move
  always_comb begin
    x       = pos[7:4];
    y       = pos[3:0];
    nx      = x;
    ny      = y;
    at_edge = 1'b0;
    case (dir[1:0])
      DIR_UP: begin
        if (y == GRID_MIN) at_edge = 1'b1;
        else               ny = y - 4'd1;
      end
      DIR_RIGHT: begin
        if (x == GRID_MAX) at_edge = 1'b1;
        else               nx = x + 4'd1;
      end
      DIR_DOWN: begin
        if (y == GRID_MAX) at_edge = 1'b1;
        else               ny = y + 4'd1;
      end
      default: begin
        if (x == GRID_MIN) at_edge = 1'b1;
        else               nx = x - 4'd1;
      end
    endcase
    new_pos = {nx, ny};
    new_dir = dir;
    if (at_edge && is_proj) new_dir[ACTIVE_BIT] = 1'b0;
  end

endmodule

// File: rtl/object_updater.sv
// Sequencer that walks the four storage objects (two tanks, two projectiles),
// reads each one, advances active objects by one grid step and writes back.
module object_updater
  import object_updater_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [3:0] mode,
  output logic       load_out,
  output logic       wren,
  output logic [7:0] address,
  output logic [7:0] data,
  input  logic [7:0] updated_pos,
  input  logic [7:0] updated_dir
);

  logic [2:0] state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [7:0] cap_pos_q, cap_pos_d;
  logic [7:0] cap_dir_q, cap_dir_d;
  logic [7:0] res_pos_q, res_pos_d;
  logic [7:0] res_dir_q, res_dir_d;

  logic [7:0] step_pos;
  logic [7:0] step_dir;

  pos_step u_pos_step (
    .pos     (cap_pos_q),
    .dir     (cap_dir_q),
    .is_proj (slot_is_proj(slot_q)),
    .new_pos (step_pos),
    .new_dir (step_dir)
  );

  // Next-state logic: read, wait for storage, compute, optionally write, advance
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    cap_pos_d = cap_pos_q;
    cap_dir_d = cap_dir_q;
    res_pos_d = res_pos_q;
    res_dir_d = res_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          slot_d  = 2'd0;
        end
      end
      ST_READ: state_d = ST_WAIT;
      ST_WAIT: begin
        cap_pos_d = updated_pos;
        cap_dir_d = updated_dir;
        state_d   = ST_CALC;
      end
      ST_CALC: begin
        res_pos_d = step_pos;
        res_dir_d = step_dir;
        if (cap_dir_q[ACTIVE_BIT]) begin
          state_d = ST_WRITE;
        end else if (slot_q == LAST_SLOT) begin
          state_d = ST_DONE;
        end else begin
          slot_d  = slot_q + 2'd1;
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        if (slot_q == LAST_SLOT) begin
          state_d = ST_DONE;
        end else begin
          slot_d  = slot_q + 2'd1;
          state_d = ST_READ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset returns everything to an idle, zeroed controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      slot_q    <= 2'd0;
      cap_pos_q <= 8'h00;
      cap_dir_q <= 8'h00;
      res_pos_q <= 8'h00;
      res_dir_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      cap_pos_q <= cap_pos_d;
      cap_dir_q <= cap_dir_d;
      res_pos_q <= res_pos_d;
      res_dir_q <= res_dir_d;
    end
  end

  // Output decode from state so reset clears every strobe immediately
  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    load_out = (state_q == ST_READ);
    wren     = (state_q == ST_WRITE);
    mode     = MODE_NONE;
    address  = 8'h00;
    data     = 8'h00;
    if (load_out || wren) mode = slot_mode(slot_q);
    if (wren) begin
      address = res_pos_q;
      data    = res_dir_q;
    end
  end

endmodule

// File: tb/tb_object_updater.sv
// Bench for object_updater: emulates the object storage, logs strobes and
// compares each pass against a reference model of the movement rules.
module tb_object_updater;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] mode;
  logic       load_out;
  logic       wren;
  logic [7:0] address;
  logic [7:0] data;
  logic [7:0] updated_pos = 8'h00;
  logic [7:0] updated_dir = 8'h00;

  int tests = 0;
  int fails = 0;
  int done_count = 0;
  int last_lat = 0;

  logic [7:0] mem_pos [4];
  logic [7:0] mem_dir [4];
  logic [3:0] w_mode [$];
  logic [7:0] w_addr [$];
  logic [7:0] w_data [$];
  logic [3:0] rd_modes [$];

  bit drive_next = 1'b0;
  int pend_slot = 0;

  object_updater dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mode        (mode),
    .load_out    (load_out),
    .wren        (wren),
    .address     (address),
    .data        (data),
    .updated_pos (updated_pos),
    .updated_dir (updated_dir)
  );

  always #5 clk = ~clk;

  function automatic int code_to_slot(input logic [3:0] m);
    case (m)
      4'b0001: return 0;
      4'b0011: return 1;
      4'b0101: return 2;
      default: return 3;
    endcase
  endfunction

  // Reference movement rules using plain integer coordinates
  function automatic void model(input int slot, input logic [7:0] p, input logic [7:0] d,
                                output bit wr, output logic [7:0] a, output logic [7:0] dd);
    int x, y, nx, ny;
    x = int'(p[7:4]);
    y = int'(p[3:0]);
    nx = x;
    ny = y;
    dd = d;
    wr = d[7];
    case (d[1:0])
      2'd0: ny = y - 1;
      2'd1: nx = x + 1;
      2'd2: ny = y + 1;
      default: nx = x - 1;
    endcase
    if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
      nx = x;
      ny = y;
      if (slot >= 2) dd[7] = 1'b0;
    end
    a = {nx[3:0], ny[3:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Storage emulation plus strobe logging; read data is valid only the cycle after load_out
  always @(negedge clk) begin
    if (drive_next) begin
      updated_pos = mem_pos[pend_slot];
      updated_dir = mem_dir[pend_slot];
      drive_next  = 1'b0;
    end else begin
      updated_pos = 8'($urandom);
      updated_dir = 8'($urandom);
    end
    if (load_out) begin
      pend_slot  = code_to_slot(mode);
      drive_next = 1'b1;
      rd_modes.push_back(mode);
    end
    if (wren) begin
      w_mode.push_back(mode);
      w_addr.push_back(address);
      w_data.push_back(data);
    end
    if (done) done_count++;
    tests++;
    assert (!(load_out && wren)) else begin
      fails++;
      $error("FAIL strobe_overlap: observed load_out=%0b wren=%0b expected not both", load_out, wren);
    end
    tests++;
    assert (load_out || wren || mode === 4'b0000) else begin
      fails++;
      $error("FAIL idle_mode: observed %0h expected 0", mode);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_load"}, load_out, 0);
    check({tag, "_wren"}, wren, 0);
    check({tag, "_mode"}, mode, 0);
    check({tag, "_addr"}, address, 0);
    check({tag, "_data"}, data, 0);
  endtask

  function automatic int count_writes(input logic [3:0] m);
    int c = 0;
    foreach (w_mode[i]) if (w_mode[i] === m) c++;
    return c;
  endfunction

  function automatic int find_write(input logic [3:0] m);
    foreach (w_mode[i]) if (w_mode[i] === m) return i;
    return -1;
  endfunction

  // One full pass: start, optional stray start while busy, then compare against the model
  task automatic run_pass(input string tag, input int restart_at);
    int n, exp_lat, wi, d0;
    bit wr;
    logic [7:0] ea, ed;
    logic [3:0] codes [4];
    codes = '{4'b0001, 4'b0011, 4'b0101, 4'b0111};
    w_mode.delete();
    w_addr.delete();
    w_data.delete();
    rd_modes.delete();
    d0 = done_count;
    exp_lat = 0;
    for (int s = 0; s < 4; s++) exp_lat += mem_dir[s][7] ? 4 : 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({tag, "_busy"}, busy, 1);
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      start = (n == restart_at);
    end
    start = 1'b0;
    last_lat = n - 1;
    check({tag, "_latency"}, last_lat, exp_lat);
    repeat (3) @(negedge clk);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_donecount"}, done_count - d0, 1);
    check({tag, "_reads"}, rd_modes.size(), 4);
    for (int s = 0; s < 4; s++)
      if (s < rd_modes.size()) check({tag, "_readmode"}, rd_modes[s], codes[s]);
    wi = 0;
    for (int s = 0; s < 4; s++) begin
      model(s, mem_pos[s], mem_dir[s], wr, ea, ed);
      if (wr) begin
        if (wi < w_mode.size()) begin
          check({tag, "_wmode"}, w_mode[wi], codes[s]);
          check({tag, "_waddr"}, w_addr[wi], ea);
          check({tag, "_wdata"}, w_data[wi], ed);
        end
        wi++;
      end
    end
    check({tag, "_wcount"}, w_mode.size(), wi);
  endtask

  task automatic set_obj(input int s, input logic [7:0] p, input logic [7:0] d);
    mem_pos[s] = p;
    mem_dir[s] = d;
  endtask

  initial begin
    int idx, wc, n;
    for (int s = 0; s < 4; s++) set_obj(s, 8'h00, 8'h00);

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // All active, tank1 moves right from 55
    set_obj(0, 8'h55, 8'h81);
    set_obj(1, 8'h22, 8'h82);
    set_obj(2, 8'h77, 8'h83);
    set_obj(3, 8'h99, 8'h80);
    run_pass("allactive", 0);
    check("allactive_lat16", last_lat, 16);
    idx = find_write(4'b0001);
    check("tank1_found", idx >= 0, 1);
    if (idx >= 0) begin
      check("tank1_addr", w_addr[idx], 8'h65);
      check("tank1_data", w_data[idx], 8'h81);
    end

    // Tank at right edge clamps
    set_obj(0, 8'hF3, 8'h81);
    run_pass("tankedge", 0);
    idx = find_write(4'b0001);
    if (idx >= 0) begin
      check("tankedge_addr", w_addr[idx], 8'hF3);
      check("tankedge_data", w_data[idx], 8'h81);
    end else check("tankedge_found", 0, 1);

    // Projectile at top edge deactivates
    set_obj(2, 8'h40, 8'h80);
    run_pass("projedge", 0);
    idx = find_write(4'b0101);
    if (idx >= 0) begin
      check("projedge_addr", w_addr[idx], 8'h40);
      check("projedge_data", w_data[idx], 8'h00);
    end else check("projedge_found", 0, 1);

    // Inactive slot 2 is skipped
    set_obj(0, 8'h55, 8'h81);
    set_obj(2, 8'h33, 8'h02);
    run_pass("inactive", 0);
    check("inactive_lat15", last_lat, 15);
    check("inactive_nowrite", count_writes(4'b0101), 0);

    // Stray start while busy is ignored
    set_obj(2, 8'h33, 8'h82);
    run_pass("restart", 5);

    // Reset during slot-1 WAIT aborts the pass
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(load_out && mode === 4'b0011) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("slot1_read_seen", n < 40, 1);
    @(negedge clk);
    wc = w_mode.size();
    reset = 1'b1;
    #1;
    check_all_zero("midreset_now");
    @(negedge clk);
    check_all_zero("midreset_next");
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("midreset_nowrite", w_mode.size(), wc);
    check("midreset_idle", busy, 0);
    run_pass("afterreset", 0);

    // Randomized passes, biased towards grid edges
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < 4; s++) begin
        mem_pos[s] = 8'($urandom);
        mem_dir[s] = 8'($urandom);
        case ($urandom_range(0, 3))
          0: mem_pos[s][7:4] = 4'h0;
          1: mem_pos[s][7:4] = 4'hF;
          2: mem_pos[s][3:0] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'hF;
          default: ;
        endcase
      end
      run_pass("rand", 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/object_updater.md
OBJECT_UPDATER -- requirements
Module: object_updater

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: start  input  1  single-cycle request to run one update pass over all four objects.
REQ-004 SHALL have port: busy  output  1  high while a pass is in progress.
REQ-005 SHALL have port: done  output  1  one-cycle pulse when a pass completes.
REQ-006 SHALL have port: mode  output  4  storage object select: tank1=0001, tank2=0011, proj1=0101, proj2=0111.
REQ-007 SHALL have port: load_out  output  1  one-cycle read strobe to storage.
REQ-008 SHALL have port: wren  output  1  one-cycle write strobe to storage.
REQ-009 SHALL have port: address  output  8  new position on write ({x[3:0],y[3:0]}); 8'h00 otherwise.
REQ-010 SHALL have port: data  output  8  direction byte on write; 8'h00 otherwise.
REQ-011 SHALL have port: updated_pos  input  8  storage read data, position {x,y}, valid the cycle after load_out.
REQ-012 SHALL have port: updated_dir  input  8  storage read data, direction, valid the cycle after load_out; bit7=active, bits[1:0]: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1).

Function
REQ-013 SHALL implement FSM states IDLE, READ, WAIT, CALC, WRITE, DONE.
REQ-014 IDLE: start=1 -> READ with slot=0; start while not IDLE SHALL be ignored.
REQ-015 READ: load_out=1 and mode=code(slot) for exactly one cycle -> WAIT.
REQ-016 WAIT: updated_pos/updated_dir SHALL be captured into internal registers at the end of this cycle -> CALC.
REQ-017 CALC: next position and direction computed from captured values -> WRITE if captured dir bit7=1, else straight to slot advance.
REQ-018 WRITE: wren=1, mode=code(slot), address=new pos, data=new dir for exactly one cycle.
REQ-019 Slot advance: slot<3 -> slot+1, READ; slot=3 -> DONE.
REQ-020 DONE: done=1 for one cycle -> IDLE; busy low in IDLE only.
REQ-021 Active slot pass latency SHALL be 4 cycles; inactive slot 3 cycles; full pass with all active = 16 cycles from start to done.
REQ-022 Tanks (slots 0,1) at grid edge moving outward SHALL keep position unchanged, direction unchanged (clamp, no wrap).
REQ-023 Projectiles (slots 2,3) at grid edge moving outward SHALL keep position and write direction with bit7 cleared (deactivate).
REQ-024 Non-edge moves SHALL change exactly one 4-bit coordinate by ±1; direction bits[6:2] SHALL be passed through unchanged.
REQ-025 load_out and wren SHALL never be high in the same cycle; mode SHALL be 4'b0000 when neither strobe is high.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, slot=0, captured registers=0, and busy, done, load_out, wren, mode, address, data all 0.
REQ-027 Reset asserted mid-pass SHALL abort with no further strobes; a WRITE in progress is truncated and not retried.

Structure
REQ-028 A shared package object_updater_pkg SHALL hold the four mode codes, direction encodings, active-bit index, grid max (4'hF) and the state encoding.
REQ-029 Next-position arithmetic SHALL be a combinational sub-module pos_step (inputs pos, dir, is_proj; outputs new_pos, new_dir).

Verification
REQ-030 All four slots active, tank1 pos 8'h55 dir 8'h81 -> tank1 write address 8'h65, data 8'h81; done exactly 16 cycles after start.
REQ-031 Tank1 pos 8'hF3 dir 8'h81 (right at edge) -> write address 8'hF3, data 8'h81.
REQ-032 Proj1 pos 8'h40 dir 8'h80 (up at y=0) -> write address 8'h40, data 8'h00.
REQ-033 Slot 2 dir 8'h02 (inactive) -> no wren with mode 0101; pass completes in 15 cycles.
REQ-034 reset pulsed during slot-1 WAIT -> all outputs 0 next cycle, no wren; subsequent start runs a clean full pass from slot 0.
REQ-035 start pulsed again while busy -> ignored; exactly one done pulse per pass.
